// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
//   imem_req   : request valid (fetch unit -> memory)
//   imem_addr  : word address, held stable while imem_req=1 and imem_ack=0
//   imem_ack   : response valid, only meaningful while imem_req=1
//   imem_rdata : instruction word, valid with imem_ack
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine feeding the IF/ID pipeline register.
// Owns the PC, requests words from instruction memory over a req/ack bus,
// buffers returned words in a head entry plus one skid entry, and presents
// {PC+4, instruction} to IF/ID. Honours the IF/ID stall and flushes on redirects.
// Optional feature macro: MISALIGN_CHECK_EN (reports misaligned redirect targets).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   Block_PC_Write    : IF/ID holding; head entry is not consumed this cycle
//   redirect_valid    : 1-cycle branch/jump redirect pulse
//   redirect_target   : new PC for the redirect
//   imem              : instruction-memory bus (master side)
//   out_PC_4          : PC+4 of the head entry
//   out_Instruction   : head instruction, NOP_WORD when no valid entry
//   out_valid         : head entry valid
//   fetch_misalign    : 1-cycle pulse on misaligned redirect (feature build only)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Block_PC_Write,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            out_PC_4,
  output logic [31:0]            out_Instruction,
  output logic                   out_valid,
  output logic                   fetch_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              head_valid_q, head_valid_d;
  logic [XLEN-1:0]   head_pc4_q, head_pc4_d;
  logic [XLEN-1:0]   head_instr_q, head_instr_d;
  logic              skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]   skid_pc4_q, skid_pc4_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              misalign_q, misalign_d;

  logic              ack_c;
  logic              consume_c;
  logic [XLEN-1:0]   pc_plus4_c;

`ifndef MISALIGN_CHECK_EN
  // Low target bits are dropped silently in this build.
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^redirect_target[1:0];
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      head_valid_q <= 1'b0;
      head_pc4_q   <= '0;
      head_instr_q <= NOP_WORD;
      skid_valid_q <= 1'b0;
      skid_pc4_q   <= '0;
      skid_instr_q <= NOP_WORD;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      head_valid_q <= head_valid_d;
      head_pc4_q   <= head_pc4_d;
      head_instr_q <= head_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      misalign_q   <= misalign_d;
    end
  end

  // Next-state, buffer and request logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    head_valid_d = head_valid_q;
    head_pc4_d   = head_pc4_q;
    head_instr_d = head_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    misalign_d   = 1'b0;

    // Acks are only honoured while a request is actually on the bus.
    ack_c      = imem.imem_ack & req_q;
    consume_c  = ~Block_PC_Write & head_valid_q;
    pc_plus4_c = pc_q + XLEN'(4);

    if (consume_c) begin
      head_valid_d = 1'b0;
      head_instr_d = NOP_WORD;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ack_c) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (!head_valid_q || !Block_PC_Write) begin
            head_valid_d = 1'b1;
            head_pc4_d   = pc_plus4_c;
            head_instr_d = imem.imem_rdata;
            pc_d         = pc_plus4_c;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc4_d   = pc_plus4_c;
            skid_instr_d = imem.imem_rdata;
            pc_d         = pc_plus4_c;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!Block_PC_Write) begin
          head_valid_d = skid_valid_q;
          head_pc4_d   = skid_pc4_q;
          head_instr_d = skid_valid_q ? skid_instr_q : NOP_WORD;
          skid_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides stall and ack; an in-flight request is tracked by kill.
    if (redirect_valid) begin
      pc_d         = {redirect_target[31:2], 2'b00};
      head_valid_d = 1'b0;
      head_instr_d = NOP_WORD;
      skid_valid_d = 1'b0;
      state_d      = S_REQ;
      kill_d       = req_q & ~ack_c;
`ifdef MISALIGN_CHECK_EN
      misalign_d   = |redirect_target[1:0];
`endif
    end

    req_d  = (state_d == S_REQ);
    // Address must not move while a request waits for its ack.
    addr_d = (req_q && !ack_c) ? addr_q : pc_d;
  end

  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign out_PC_4        = head_pc4_q;
  assign out_Instruction = head_instr_q;
  assign out_valid       = head_valid_q;
  assign fetch_misalign  = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a memory model with random latency and
// a program-order stream model that predicts every word IF/ID consumes.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        blk;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] out_PC_4;
  logic [31:0] out_Instruction;
  logic        out_valid;
  logic        fetch_misalign;

  if_fetch_unit_if imem_bus();

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .Block_PC_Write  (blk),
    .redirect_valid  (redir),
    .redirect_target (redir_tgt),
    .imem            (imem_bus),
    .out_PC_4        (out_PC_4),
    .out_Instruction (out_Instruction),
    .out_valid       (out_valid),
    .fetch_misalign  (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;

  // Reference state: next program-order PC IF/ID should receive.
  logic [31:0] exp_pc;
  int          fixed_lat = 0;
  int          max_lat   = 0;
  bit          spur_en   = 0;
  bit          mem_busy  = 0;
  int          mem_wait  = 0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_addr = '0;
  int          consumed  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory response, stream scoreboard, then advance.
  task automatic tick();
    logic [31:0] e_pc4;
    if (reset) begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = '0;
      mem_busy = 0;
    end else if (imem_bus.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat, 0));
      end
      if (mem_wait == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        mem_busy = 0;
      end else begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom;
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
      imem_bus.imem_ack   = spur_en && ($urandom_range(3, 0) == 0);
      imem_bus.imem_rdata = $urandom;
    end

    if (!reset) begin
      if (prev_req && !prev_ack) begin
        n_vec++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h",
                   imem_bus.imem_req, imem_bus.imem_addr, prev_addr);
        end
      end
      if (out_valid && !blk) begin
        e_pc4 = exp_pc + 32'd4;
        n_vec++;
        consumed++;
        if (out_PC_4 !== e_pc4 || out_Instruction !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL stream: got pc4=%h instr=%h, required pc4=%h instr=%h",
                   out_PC_4, out_Instruction, e_pc4, mem_word(exp_pc));
        end
        exp_pc = e_pc4;
      end else if (!out_valid) begin
        n_vec++;
        if (out_Instruction !== NOP) begin
          n_fail++;
          $display("FAIL bubble_nop: got instr=%h, required %h", out_Instruction, NOP);
        end
      end
      if (redir) exp_pc = {redir_tgt[31:2], 2'b00};
    end

    prev_req  = reset ? 1'b0 : imem_bus.imem_req;
    prev_ack  = imem_bus.imem_ack;
    prev_addr = imem_bus.imem_addr;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a request on the bus (optionally a freshly issued one).
  task automatic wait_req(input bit fresh, input string tag);
    for (int i = 0; i < 30; i++) begin
      if (imem_bus.imem_req && (!fresh || !mem_busy)) return;
      tick();
    end
    n_vec++;
    n_fail++;
    $display("FAIL %s_timeout: no request within 30 cycles, required one", tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; blk = 1'b0; redir = 1'b0; redir_tgt = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    tick();
    tick();
    n_vec++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, required 0", imem_bus.imem_req); end
    n_vec++; if (imem_bus.imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h, required %h", imem_bus.imem_addr, RST_PC); end
    n_vec++; if (out_PC_4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h, required 0", out_PC_4); end
    n_vec++; if (out_Instruction !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h, required %h", out_Instruction, NOP); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    n_vec++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b, required 0", fetch_misalign); end
  endtask

  task automatic test_startup();
    int vcnt;
    fixed_lat = 0;
    exp_pc = RST_PC;
    reset = 1'b0;
    tick();
    n_vec++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_first_req: req=%b addr=%h valid=%b, required 1 %h 0",
               imem_bus.imem_req, imem_bus.imem_addr, out_valid, RST_PC);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0004 || imem_bus.imem_addr !== 32'h0040_0004) begin
      n_fail++;
      $display("FAIL start_first_word: valid=%b pc4=%h addr=%h, required 1 00400004 00400004",
               out_valid, out_PC_4, imem_bus.imem_addr);
    end
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) vcnt++;
    end
    n_vec++;
    if (vcnt != 8 || out_PC_4 !== 32'h0040_0024) begin
      n_fail++;
      $display("FAIL throughput: valid cycles=%0d pc4=%h, required 8 00400024", vcnt, out_PC_4);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit          held_ok;
    bit          saw_idle;
    fixed_lat = 0;
    held = out_PC_4;
    held_ok = 1;
    saw_idle = 0;
    blk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_PC_4 !== held || out_valid !== 1'b1) held_ok = 0;
      if (imem_bus.imem_req === 1'b0) saw_idle = 1;
    end
    n_vec++;
    if (!held_ok || !saw_idle) begin
      n_fail++;
      $display("FAIL stall_hold: held=%b req_dropped=%b, required 1 1", held_ok, saw_idle);
    end
    blk = 1'b0;
    tick();
    n_vec++;
    if (out_PC_4 !== held + 32'd4) begin
      n_fail++;
      $display("FAIL stall_skid: got pc4=%h, required %h", out_PC_4, held + 32'd4);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_redirect_outstanding();
    int cnt;
    fixed_lat = 2;
    wait_req(1, "redir_out");
    redir = 1'b1; redir_tgt = 32'h0040_0100;
    tick();
    redir = 1'b0;
    cnt = 0;
    while (!(imem_bus.imem_req && imem_bus.imem_addr == 32'h0040_0100) && cnt < 20) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL redir_kill_latency: new addr after %0d cycles, required 2", cnt);
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (out_PC_4 !== 32'h0040_0104 || out_Instruction !== mem_word(32'h0040_0100)) begin
      n_fail++;
      $display("FAIL redir_first_word: got pc4=%h instr=%h, required 00400104 %h",
               out_PC_4, out_Instruction, mem_word(32'h0040_0100));
    end
  endtask

  task automatic test_redirect_with_ack();
    fixed_lat = 0;
    wait_req(0, "redir_ack");
    redir = 1'b1; redir_tgt = 32'h0040_0200;
    tick();
    redir = 1'b0;
    n_vec++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0200) begin
      n_fail++;
      $display("FAIL redir_ack_addr: req=%b addr=%h, required 1 00400200",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_PC_4 !== 32'h0040_0204) begin
      n_fail++;
      $display("FAIL redir_ack_word: valid=%b pc4=%h, required 1 00400204", out_valid, out_PC_4);
    end
  endtask

  task automatic test_wrap();
    fixed_lat = 0;
    wait_req(0, "wrap");
    redir = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    n_vec++;
    if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_addr0: got %h, required fffffffc", imem_bus.imem_addr);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_PC_4 !== 32'h0 || imem_bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: valid=%b pc4=%h addr=%h, required 1 00000000 00000000",
               out_valid, out_PC_4, imem_bus.imem_addr);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_misalign();
    logic exp_pulse;
`ifdef MISALIGN_CHECK_EN
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif
    fixed_lat = 0;
    wait_req(0, "misalign");
    redir = 1'b1; redir_tgt = 32'h0040_0102;
    tick();
    redir = 1'b0;
    n_vec++;
    if (fetch_misalign !== exp_pulse || imem_bus.imem_addr !== 32'h0040_0100) begin
      n_fail++;
      $display("FAIL misalign_pulse: flag=%b addr=%h, required %b 00400100",
               fetch_misalign, imem_bus.imem_addr, exp_pulse);
    end
    tick();
    n_vec++;
    if (fetch_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_len: got %b, required 0", fetch_misalign);
    end
  endtask

  task automatic test_reset_mid();
    fixed_lat = 3;
    wait_req(1, "rst_mid");
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (imem_bus.imem_req !== 1'b0 || out_valid !== 1'b0 || imem_bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_mid: req=%b valid=%b addr=%h, required 0 0 %h",
               imem_bus.imem_req, out_valid, imem_bus.imem_addr, RST_PC);
    end
    reset = 1'b0;
    exp_pc = RST_PC;
    fixed_lat = 0;
    tick();
    n_vec++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_mid_restart: req=%b addr=%h, required 1 %h",
               imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    int start;
    start = consumed;
    fixed_lat = -1;
    max_lat = 3;
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      blk   = ($urandom_range(9, 0) < 3);
      redir = ($urandom_range(31, 0) == 0);
      redir_tgt = RST_PC + {22'd0, 8'($urandom_range(255, 0)), 2'($urandom_range(3, 0))};
      tick();
    end
    blk = 1'b0; redir = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_vec++;
    if (consumed - start < 500) begin
      n_fail++;
      $display("FAIL random_progress: %0d words consumed, required at least 500", consumed - start);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
